// File: rtl/address_translator.sv
// Translates a raw partial address into a zero-based index within a (possibly wrapping) window.
// Optional saturating miss counter is built when ADDRESS_TRANSLATOR_MISS_COUNT_EN is defined.
module address_translator #(
  parameter int ADDR_COUNT       = 0,
  parameter int ADDR_BASE        = 0,
  parameter int ADDR_WIDTH       = 0,
  parameter int MISS_COUNT_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [ADDR_WIDTH-1:0]       raw_address,
  input  logic                        raw_valid,
  output logic [ADDR_WIDTH-1:0]       translated_address,
  output logic                        in_range,
  output logic [ADDR_WIDTH-1:0]       translated_address_q,
  output logic                        in_range_q,
  output logic [MISS_COUNT_WIDTH-1:0] miss_count
);

  localparam logic [ADDR_WIDTH-1:0] BASE_LO = ADDR_BASE[ADDR_WIDTH-1:0];
  // One extra bit so a window covering the whole address space compares correctly.
  localparam logic [ADDR_WIDTH:0]   COUNT_C = ADDR_COUNT[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] offset;

  // Modular subtraction: the discarded carry is what makes the window wrap.
  assign offset             = raw_address - BASE_LO;
  assign in_range           = ({1'b0, offset} < COUNT_C);
  assign translated_address = in_range ? offset : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      translated_address_q <= '0;
      in_range_q           <= 1'b0;
    end else begin
      translated_address_q <= translated_address;
      in_range_q           <= raw_valid & in_range;
    end
  end

`ifdef ADDRESS_TRANSLATOR_MISS_COUNT_EN
  logic [MISS_COUNT_WIDTH-1:0] miss_cnt_q;
  logic [MISS_COUNT_WIDTH-1:0] miss_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (raw_valid && !in_range && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) miss_cnt_q <= '0;
    else          miss_cnt_q <= miss_cnt_d;
  end

  assign miss_count = miss_cnt_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_address_translator.sv
// Self-checking bench for address_translator: vector tables, corner sequences, and
// randomized traffic against a modular-arithmetic reference model.
module tb_address_translator;

`ifdef ADDRESS_TRANSLATOR_MISS_COUNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clock;
  logic reset_n;

  // Instance A: width 2, base 0x1F3, count 3 (wrapping window)
  logic [1:0] raw_a, ta_a, taq_a;
  logic       val_a, ir_a, irq_a;
  logic [7:0] mc_a;
  // Instance B: width 3, base 0, count 8 (identity, full space)
  logic [2:0] raw_b, ta_b, taq_b;
  logic       val_b, ir_b, irq_b;
  logic [7:0] mc_b;
  // Instance C: width 3, base 5, count 4, 2-bit miss counter
  logic [2:0] raw_c, ta_c, taq_c;
  logic       val_c, ir_c, irq_c;
  logic [1:0] mc_c;

  address_translator #(.ADDR_COUNT(3), .ADDR_BASE(32'h1F3), .ADDR_WIDTH(2), .MISS_COUNT_WIDTH(8)) u_a (
    .clock(clock), .reset_n(reset_n), .raw_address(raw_a), .raw_valid(val_a),
    .translated_address(ta_a), .in_range(ir_a), .translated_address_q(taq_a),
    .in_range_q(irq_a), .miss_count(mc_a));

  address_translator #(.ADDR_COUNT(8), .ADDR_BASE(0), .ADDR_WIDTH(3), .MISS_COUNT_WIDTH(8)) u_b (
    .clock(clock), .reset_n(reset_n), .raw_address(raw_b), .raw_valid(val_b),
    .translated_address(ta_b), .in_range(ir_b), .translated_address_q(taq_b),
    .in_range_q(irq_b), .miss_count(mc_b));

  address_translator #(.ADDR_COUNT(4), .ADDR_BASE(5), .ADDR_WIDTH(3), .MISS_COUNT_WIDTH(2)) u_c (
    .clock(clock), .reset_n(reset_n), .raw_address(raw_c), .raw_valid(val_c),
    .translated_address(ta_c), .in_range(ir_c), .translated_address_q(taq_c),
    .in_range_q(irq_c), .miss_count(mc_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: window membership from plain modular arithmetic.
  function automatic int ref_offset(input int raw, input int base, input int width);
    int m;
    m = 1 << width;
    return ((raw - (base % m)) % m + m) % m;
  endfunction

  typedef struct {
    logic [2:0] raw;
    logic [2:0] exp_t;
    logic       exp_in;
  } vec_t;

  vec_t vec_a[4];
  vec_t vec_b[8];

  // Model state for instance C
  int m_taq, m_irq, m_miss;

  task automatic model_edge_c(input int raw, input bit valid);
    int off;
    bit inr;
    off = ref_offset(raw, 5, 3);
    inr = (off < 4);
    m_taq = inr ? off : 0;
    m_irq = (valid && inr) ? 1 : 0;
    if (valid && !inr && m_miss < 3) m_miss++;
  endtask

  task automatic check_regs_c(input string tag);
    check({tag, " taq_c"}, 32'(taq_c), 32'(m_taq));
    check({tag, " irq_c"}, 32'(irq_c), 32'(m_irq));
    check({tag, " mc_c"},  32'(mc_c),  MISS_EN ? 32'(m_miss) : 32'd0);
  endtask

  initial begin
    vec_a[0] = '{3'd0, 3'd1, 1'b1};
    vec_a[1] = '{3'd1, 3'd2, 1'b1};
    vec_a[2] = '{3'd2, 3'd0, 1'b0};
    vec_a[3] = '{3'd3, 3'd0, 1'b1};
    for (int i = 0; i < 8; i++) vec_b[i] = '{3'(i), 3'(i), 1'b1};

    reset_n = 1'b0;
    raw_a = '0; val_a = 1'b0;
    raw_b = '0; val_b = 1'b0;
    raw_c = 3'd6; val_c = 1'b1;
    m_taq = 0; m_irq = 0; m_miss = 0;

    // Reset held across clock edges with an in-range access presented
    #12;
    check("rst taq_c", 32'(taq_c), 32'd0);
    check("rst irq_c", 32'(irq_c), 32'd0);
    check("rst mc_c",  32'(mc_c),  32'd0);
    check("rst comb ta_c", 32'(ta_c), 32'd1);
    check("rst comb ir_c", 32'(ir_c), 32'd1);

    // Release; first edge captures raw=6 -> index 1
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    model_edge_c(6, 1'b1);
    check_regs_c("post-rst");

    // Combinational sweeps from tables
    for (int i = 0; i < 4; i++) begin
      raw_a = vec_a[i].raw[1:0];
      #1;
      check($sformatf("A raw%0d ta", i), 32'(ta_a), 32'(vec_a[i].exp_t[1:0]));
      check($sformatf("A raw%0d ir", i), 32'(ir_a), 32'(vec_a[i].exp_in));
    end
    for (int i = 0; i < 8; i++) begin
      raw_b = vec_b[i].raw;
      #1;
      check($sformatf("B raw%0d ta", i), 32'(ta_b), 32'(vec_b[i].exp_t));
      check($sformatf("B raw%0d ir", i), 32'(ir_b), 32'(vec_b[i].exp_in));
    end

    // Registered path on A, including raw_valid gating of in_range_q
    @(negedge clock); raw_a = 2'd1; val_a = 1'b0;
    @(posedge clock); #1;
    check("A q valid0 taq", 32'(taq_a), 32'd2);
    check("A q valid0 irq", 32'(irq_a), 32'd0);

    // Saturating miss counter on C: 5 valid misses, then an invalid miss
    @(negedge clock); reset_n = 1'b0; m_taq = 0; m_irq = 0; m_miss = 0;
    #1; check("C mid rst mc", 32'(mc_c), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); raw_c = 3'd1; val_c = 1'b1;
      @(posedge clock); #1;
      model_edge_c(1, 1'b1);
      check_regs_c($sformatf("sat%0d", k));
    end
    @(negedge clock); raw_c = 3'd2; val_c = 1'b0;
    @(posedge clock); #1;
    model_edge_c(2, 1'b0);
    check_regs_c("sat invalid");

    // Async reset mid-cycle with counter at 2
    @(negedge clock); reset_n = 1'b0; m_taq = 0; m_irq = 0; m_miss = 0;
    #1; reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); raw_c = 3'd4; val_c = 1'b1;
      @(posedge clock); #1;
      model_edge_c(4, 1'b1);
    end
    check("pre-async mc", 32'(mc_c), MISS_EN ? 32'd2 : 32'd0);
    #1; reset_n = 1'b0; m_taq = 0; m_irq = 0; m_miss = 0;
    #1;
    check_regs_c("async");
    @(negedge clock); reset_n = 1'b1;

    // Randomized traffic on C
    for (int k = 0; k < 300; k++) begin
      int r;
      bit v;
      int off;
      @(negedge clock);
      r = int'($urandom_range(0, 7));
      v = 1'($urandom_range(0, 1));
      raw_c = 3'(r); val_c = v;
      #1;
      off = ref_offset(r, 5, 3);
      check("rnd ta_c", 32'(ta_c), (off < 4) ? 32'(off) : 32'd0);
      check("rnd ir_c", 32'(ir_c), (off < 4) ? 32'd1 : 32'd0);
      @(posedge clock); #1;
      model_edge_c(r, v);
      check_regs_c("rnd");
      if (k == 150) begin
        reset_n = 1'b0; m_taq = 0; m_irq = 0; m_miss = 0;
        #1; check_regs_c("rnd rst");
        reset_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
